// File: rtl/instr_fetch_unit.sv
// Purpose : instruction memory, program counter and one-deep prefetch buffer feeding the control unit.
// Latency : 1-cycle synchronous memory read; PROG_EN low -> FETCH_READY high in 2 cycles.
// Backpres: PC_INCR is ignored while a word is buffered or a read is in flight; INSTR swaps only on INSTR_DONE.
// Ports   : CLK/RSTN clock and async active-low reset; PROG_EN/PROG_WE/PROG_ADDR/PROG_DATA host write port;
//           START_SIGNAL/STOP_SIGNAL/PC_INCR/INSTR_DONE control handshakes;
//           INSTR/PC current word and address; FETCH_READY, NEXT_VALID, PC_WRAP, HALTED status.
module instr_fetch_unit #(
  parameter int IMEM_DEPTH = 64,
  parameter int ADDR_W     = 6
) (
  input  logic              CLK,
  input  logic              RSTN,
  input  logic              PROG_EN,
  input  logic              PROG_WE,
  input  logic [ADDR_W-1:0] PROG_ADDR,
  input  logic [31:0]       PROG_DATA,
  input  logic              START_SIGNAL,
  input  logic              STOP_SIGNAL,
  input  logic              PC_INCR,
  input  logic              INSTR_DONE,
  output logic [31:0]       INSTR,
  output logic [ADDR_W-1:0] PC,
  output logic              FETCH_READY,
  output logic              NEXT_VALID,
  output logic              PC_WRAP,
  output logic              HALTED
);

  typedef enum logic [2:0] {S_PROG, S_PRIME, S_READY, S_RUN, S_HALT} state_t;

  state_t r_state, w_state_nxt;

  logic [31:0]       r_mem [IMEM_DEPTH];
  logic [31:0]       r_mem_q;
  logic [31:0]       r_instr;
  logic [31:0]       r_next;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_next_pc;
  logic              r_next_vld;
  logic              r_inflight;
  logic              r_pending;
  logic              r_wrap;
  logic              r_prog_en_d;

  logic              w_prog_fall;
  logic              w_run_active;
  logic              w_incr_ok;
  logic              w_rd_en;
  logic              w_mem_we;
  logic [ADDR_W-1:0] w_pc_inc;
  logic [ADDR_W-1:0] w_rd_addr;

  assign w_prog_fall  = r_prog_en_d & ~PROG_EN;
  // RUN with neither abort nor stop requested this cycle.
  assign w_run_active = (r_state == S_RUN) & ~PROG_EN & ~STOP_SIGNAL;
  // A new prefetch is only legal with an empty buffer and no read outstanding.
  assign w_incr_ok    = w_run_active & PC_INCR & ~r_next_vld & ~r_inflight;
  assign w_pc_inc     = r_pc + ADDR_W'(1);
  assign w_rd_en      = ((r_state == S_PROG) & w_prog_fall) | w_incr_ok;
  assign w_rd_addr    = (r_state == S_RUN) ? w_pc_inc : '0;
  assign w_mem_we     = (r_state == S_PROG) & PROG_EN & PROG_WE;

  // Memory array and read register carry no reset.
  always_ff @(posedge CLK) begin
    if (w_mem_we) r_mem[PROG_ADDR] <= PROG_DATA;
    if (w_rd_en)  r_mem_q          <= r_mem[w_rd_addr];
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) r_state <= S_PROG;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_PROG:  if (w_prog_fall) w_state_nxt = S_PRIME;
      S_PRIME: w_state_nxt = S_READY;
      S_READY: begin
        if (PROG_EN)           w_state_nxt = S_PROG;
        else if (START_SIGNAL) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        if (PROG_EN)          w_state_nxt = S_PROG;
        else if (STOP_SIGNAL) w_state_nxt = S_HALT;
      end
      S_HALT:  if (PROG_EN) w_state_nxt = S_PROG;
      default: w_state_nxt = S_PROG;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_instr     <= '0;
      r_next      <= '0;
      r_pc        <= '0;
      r_next_pc   <= '0;
      r_next_vld  <= 1'b0;
      r_inflight  <= 1'b0;
      r_pending   <= 1'b0;
      r_wrap      <= 1'b0;
      r_prog_en_d <= 1'b0;
    end else begin
      r_prog_en_d <= PROG_EN;
      case (r_state)
        S_PRIME: begin
          r_instr <= r_mem_q;
          r_pc    <= '0;
        end
        S_RUN: begin
          if (PROG_EN) begin
            r_instr    <= '0;
            r_next_vld <= 1'b0;
            r_inflight <= 1'b0;
            r_pending  <= 1'b0;
          end else if (STOP_SIGNAL) begin
            // Outstanding read is dropped; INSTR and PC stay frozen.
            r_next_vld <= 1'b0;
            r_inflight <= 1'b0;
            r_pending  <= 1'b0;
          end else begin
            if (r_inflight) begin
              // Read returns this edge: retire straight into INSTR if the
              // control unit has already finished (or finishes now).
              r_inflight <= 1'b0;
              if (r_pending || INSTR_DONE) begin
                r_instr   <= r_mem_q;
                r_pc      <= r_next_pc;
                r_pending <= 1'b0;
              end else begin
                r_next     <= r_mem_q;
                r_next_vld <= 1'b1;
              end
            end else if (INSTR_DONE && r_next_vld) begin
              r_instr    <= r_next;
              r_pc       <= r_next_pc;
              r_next_vld <= 1'b0;
            end else if (INSTR_DONE && w_incr_ok) begin
              // Read is being launched on this same edge.
              r_pending <= 1'b1;
            end
            if (w_incr_ok) begin
              r_inflight <= 1'b1;
              r_next_pc  <= w_pc_inc;
              if (&r_pc) r_wrap <= 1'b1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign INSTR       = r_instr;
  assign PC          = r_pc;
  assign FETCH_READY = (r_state == S_READY);
  assign NEXT_VALID  = r_next_vld;
  assign PC_WRAP     = r_wrap;
  assign HALTED      = (r_state == S_HALT);

endmodule
